// File: rtl/dtree_sched.sv
// Round-robin front end for a shared decision-tree walk engine: grants one
// requester at a time, launches the walk, waits (bounded) for the leaf result.
module dtree_sched #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2,
  parameter int DW    = 8,
  parameter int NFEAT = 4,
  parameter int TMO   = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*NFEAT*DW-1:0] req_feat_i,
  output logic                     eng_start_o,
  output logic [NFEAT*DW-1:0]      eng_feat_o,
  input  logic                     eng_done_i,
  input  logic [DW-1:0]            eng_y_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [IDW-1:0]           rsp_id_o,
  output logic [DW-1:0]            rsp_y_o,
  output logic                     rsp_err_o,
  output logic                     busy_o
);

  localparam int FW = NFEAT * DW;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TMO - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;
  logic [TW-1:0]  timer;
  logic           timeout;

  // First valid requester at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && req_valid_i[(int'(rr_ptr) + i) % N_REQ]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  assign timeout = (timer == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (eng_done_i || timeout) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    eng_start_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (gnt_any && !reset) req_ready_o[gnt_id] = 1'b1;
      end
      ISSUE:   eng_start_o = 1'b1;
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Capture at grant, timer during the walk, result latched on done or abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      timer      <= '0;
      eng_feat_o <= '0;
      rsp_id_o   <= '0;
      rsp_y_o    <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            eng_feat_o <= req_feat_i[int'(gnt_id)*FW +: FW];
            rsp_id_o   <= gnt_id;
            rr_ptr     <= (gnt_id == ID_LAST) ? '0 : gnt_id + IDW'(1);
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          // done has priority over a timeout in the same cycle
          if (eng_done_i) begin
            rsp_y_o   <= eng_y_i;
            rsp_err_o <= 1'b0;
          end else if (timeout) begin
            rsp_y_o   <= '0;
            rsp_err_o <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_sched.sv
// Bench for dtree_sched: directed vector table, hand-written corner sequences
// and randomized traffic against a transaction-age reference model.
module tb_dtree_sched;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DW  = 8;
  localparam int NF  = 4;
  localparam int TMO = 8;
  localparam int FW  = NF * DW;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*FW-1:0] req_feat;
  logic            eng_start;
  logic [FW-1:0]   eng_feat;
  logic            eng_done;
  logic [DW-1:0]   eng_y;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [DW-1:0]   rsp_y;
  logic            rsp_err, busy;

  always #5 clk = ~clk;

  dtree_sched #(.N_REQ(N), .IDW(IDW), .DW(DW), .NFEAT(NF), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_feat_i(req_feat),
    .eng_start_o(eng_start), .eng_feat_o(eng_feat),
    .eng_done_i(eng_done), .eng_y_i(eng_y),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_y_o(rsp_y), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: one outstanding transaction described by its age
  // (cycles since grant) and whether its result is already known.
  bit            m_have, m_res, m_err;
  int            m_age, m_id, m_ptr;
  logic [FW-1:0] m_feat;
  logic [DW-1:0] m_y;

  // Bench-side engine: answers eng_start after e_delay cycles.
  int            e_cnt   = -1;
  int            e_delay = 2;
  logic [DW-1:0] e_y     = '0;

  logic [N-1:0]   s_ready;
  logic           s_start, s_busy, s_rv, s_err;
  logic [IDW-1:0] s_id;
  logic [DW-1:0]  s_y;
  logic [FW-1:0]  s_feat;
  int             s_cyc;
  int             grants[$];
  int             rsps[$];

  typedef struct packed {
    logic [N-1:0]   v;
    logic           d;
    logic [DW-1:0]  y;
    logic           rr;
    logic [N-1:0]   ready;
    logic           start;
    logic           bsy;
    logic           rv;
    logic [IDW-1:0] id;
    logic [DW-1:0]  ry;
    logic           err;
    logic [FW-1:0]  feat;
  } vec_t;

  vec_t tbl[7];

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic d, input logic [DW-1:0] y,
                       input logic rr, input logic rst);
    int g;
    logic [N-1:0] exp_ready;
    req_valid = v; eng_done = d; eng_y = y; rsp_ready = rr; reset = rst;
    #2;
    s_ready = req_ready; s_start = eng_start; s_busy = busy; s_rv = rsp_valid;
    s_err = rsp_err; s_id = rsp_id; s_y = rsp_y; s_feat = eng_feat; s_cyc = cyc;
    g = m_have ? -1 : pick(v, m_ptr);
    if (!rst) begin
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", 32'(s_ready), 32'(exp_ready));
      chk("eng_start", 32'(s_start), 32'(m_have && m_age == 1));
      chk("busy", 32'(s_busy), 32'(m_have));
      chk("rsp_valid", 32'(s_rv), 32'(m_have && m_res));
      chk("eng_feat", s_feat, m_feat);
      if (m_have && m_res) begin
        chk("rsp_id", 32'(s_id), 32'(m_id));
        chk("rsp_y", 32'(s_y), 32'(m_y));
        chk("rsp_err", 32'(s_err), 32'(m_err));
      end
      if (s_ready != 0) grants.push_back(oh_idx(s_ready));
      if (s_rv && rr) rsps.push_back(int'(s_id));
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_have = 0; m_res = 0; m_ptr = 0; m_feat = '0;
    end else if (!m_have) begin
      if (g >= 0) begin
        m_have = 1; m_res = 0; m_age = 1; m_id = g;
        m_feat = req_feat[g*FW +: FW];
        m_ptr  = (g + 1) % N;
      end
    end else if (m_res) begin
      if (rr) m_have = 0;
    end else begin
      if (m_age >= 2) begin
        if (d) begin
          m_res = 1; m_y = y; m_err = 0;
        end else if (m_age == TMO + 1) begin
          m_res = 1; m_y = '0; m_err = 1;
        end
      end
      m_age++;
    end
    if (rst)          e_cnt = -1;
    else if (s_start) e_cnt = e_delay - 1;
    else if (e_cnt >= 0) e_cnt--;
    #1;
  endtask

  task automatic cyc_auto(input logic [N-1:0] v, input logic rr, input logic noise,
                          input logic rst);
    logic d;
    logic [DW-1:0] y;
    d = (e_cnt == 0) || noise;
    y = (e_cnt == 0) ? e_y : 8'($urandom);
    cycle(v, d, y, rr, rst);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * TMO + 10; i++) cyc_auto('0, 1'b1, 1'b0, 1'b0);
  endtask

  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
  int g_cyc;
  logic [IDW-1:0] h_id;
  logic [DW-1:0]  h_y;
  logic           h_err;

  initial begin
    req_feat = {32'hDEADBEEF, 32'hCAFEF00D, 32'h04030201, 32'h11223344};
    //          v       d     y      rr    ready   st    bsy   rv    id     ry     err   feat
    tbl[0] = '{4'b0010, 1'b0, 8'h00, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 32'h0};
    tbl[1] = '{4'b0000, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 32'h04030201};
    tbl[2] = '{4'b0000, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 32'h04030201};
    tbl[3] = '{4'b0000, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 32'h04030201};
    tbl[4] = '{4'b0000, 1'b1, 8'h5A, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 32'h04030201};
    tbl[5] = '{4'b0000, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 8'h5A, 1'b0, 32'h04030201};
    tbl[6] = '{4'b0000, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 32'h04030201};

    cycle('0, 1'b0, '0, 1'b1, 1'b1);
    cycle('0, 1'b0, '0, 1'b1, 1'b1);

    // reset state
    cycle('0, 1'b0, '0, 1'b1, 1'b0);
    chk("rst_ready", 32'(s_ready), 32'h0);
    chk("rst_start", 32'(s_start), 32'h0);
    chk("rst_busy", 32'(s_busy), 32'h0);
    chk("rst_rv", 32'(s_rv), 32'h0);
    chk("rst_feat", s_feat, 32'h0);
    chk("rst_id", 32'(s_id), 32'h0);
    chk("rst_y", 32'(s_y), 32'h0);
    chk("rst_err", 32'(s_err), 32'h0);

    // single request, vector table
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].rr, 1'b0);
      chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_start", i), 32'(s_start), 32'(tbl[i].start));
      chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_rv", i), 32'(s_rv), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_feat", i), s_feat, tbl[i].feat);
      if (tbl[i].rv) begin
        chk($sformatf("tbl%0d_id", i), 32'(s_id), 32'(tbl[i].id));
        chk($sformatf("tbl%0d_y", i), 32'(s_y), 32'(tbl[i].ry));
        chk($sformatf("tbl%0d_err", i), 32'(s_err), 32'(tbl[i].err));
      end
    end

    // round robin with all requesters held valid
    cycle('0, 1'b0, '0, 1'b1, 1'b1);
    grants.delete(); rsps.delete();
    e_delay = 2;
    for (int i = 0; i < 100 && (grants.size() < 6 || rsps.size() < 6); i++)
      cyc_auto(4'hF, 1'b1, 1'b0, 1'b0);
    chk("rr_grants_seen", 32'(grants.size() >= 6), 32'h1);
    chk("rr_rsps_seen", 32'(rsps.size() >= 6), 32'h1);
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) chk($sformatf("rr_grant%0d", i), grants[i], exp_rr[i]);
      if (i < rsps.size())   chk($sformatf("rr_rsp%0d", i), rsps[i], exp_rr[i]);
    end
    drain();

    // timeout: engine silent
    e_delay = 1000;
    cyc_auto(4'b0100, 1'b1, 1'b0, 1'b0);
    g_cyc = s_cyc;
    chk("tmo_grant", 32'(s_ready), 32'h4);
    for (int i = 0; i < 40; i++) begin
      cyc_auto('0, 1'b1, 1'b0, 1'b0);
      if (s_rv) break;
    end
    chk("tmo_rv", 32'(s_rv), 32'h1);
    chk("tmo_latency", s_cyc - g_cyc, 32'd10);
    chk("tmo_err", 32'(s_err), 32'h1);
    chk("tmo_y", 32'(s_y), 32'h0);
    e_cnt = -1;
    cycle('0, 1'b1, 8'h77, 1'b1, 1'b0);
    chk("tmo_late_done_rv", 32'(s_rv), 32'h0);
    cycle('0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("tmo_late_done_rv2", 32'(s_rv), 32'h0);
    drain();

    // done on the last WAIT cycle wins over timeout
    e_delay = TMO; e_y = 8'h11;
    cyc_auto(4'b0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc_auto('0, 1'b1, 1'b0, 1'b0);
      if (s_rv) break;
    end
    chk("coll_rv", 32'(s_rv), 32'h1);
    chk("coll_err", 32'(s_err), 32'h0);
    chk("coll_y", 32'(s_y), 32'h11);
    drain();

    // backpressure while requester 3 waits
    e_delay = 2; e_y = 8'hA7;
    cyc_auto(4'b0010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc_auto(4'b1000, 1'b0, 1'b0, 1'b0);
      if (s_rv) break;
    end
    chk("bp_rv", 32'(s_rv), 32'h1);
    h_id = s_id; h_y = s_y; h_err = s_err;
    for (int i = 0; i < 4; i++) begin
      cyc_auto(4'b1000, 1'b0, 1'b0, 1'b0);
      chk("bp_hold_rv", 32'(s_rv), 32'h1);
      chk("bp_hold_ready", 32'(s_ready), 32'h0);
      chk("bp_hold_start", 32'(s_start), 32'h0);
      chk("bp_hold_id", 32'(s_id), 32'(h_id));
      chk("bp_hold_y", 32'(s_y), 32'(h_y));
      chk("bp_hold_err", 32'(s_err), 32'(h_err));
    end
    cyc_auto(4'b1000, 1'b1, 1'b0, 1'b0);
    chk("bp_accept_ready", 32'(s_ready), 32'h0);
    cyc_auto(4'b1000, 1'b1, 1'b0, 1'b0);
    chk("bp_grant3", 32'(s_ready), 32'h8);
    drain();

    // reset in WAIT abandons the walk
    e_delay = 5;
    cyc_auto(4'b0100, 1'b1, 1'b0, 1'b0);
    cyc_auto('0, 1'b1, 1'b0, 1'b0);
    cyc_auto('0, 1'b1, 1'b0, 1'b0);
    cyc_auto('0, 1'b1, 1'b0, 1'b1);
    cycle('0, 1'b0, '0, 1'b1, 1'b0);
    chk("mrst_busy", 32'(s_busy), 32'h0);
    chk("mrst_start", 32'(s_start), 32'h0);
    chk("mrst_rv", 32'(s_rv), 32'h0);
    chk("mrst_feat", s_feat, 32'h0);
    chk("mrst_y", 32'(s_y), 32'h0);
    chk("mrst_err", 32'(s_err), 32'h0);
    cycle('0, 1'b1, 8'h99, 1'b1, 1'b0);
    chk("mrst_stray_done", 32'(s_rv), 32'h0);
    cyc_auto(4'b1001, 1'b1, 1'b0, 1'b0);
    chk("mrst_ptr0_grant", 32'(s_ready), 32'h1);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_feat = {$urandom(), $urandom(), $urandom(), $urandom()};
      e_delay  = 1 + int'($urandom_range(TMO + 2));
      e_y      = 8'($urandom);
      cyc_auto(N'($urandom), ($urandom_range(3) != 0), ($urandom_range(15) == 0),
               ($urandom_range(399) == 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dtree_sched.md
Name: dtree_sched

Overview:
Round-robin scheduler that shares one decision-tree walk engine between N_REQ requesters. It accepts one feature vector at a time from a requester and launches a tree walk on the engine. It waits for the leaf result, bounding the wait with a timeout, then returns the result tagged with the requester id. It sits between the client blocks and the tree-walk engine, and is the only block that drives the engine's start.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDW, 2, id width = clog2(N_REQ)
DW, 8, feature and result data width
NFEAT, 4, features per request vector
TMO, 255, max cycles waited for eng_done_i before abort (1..2**16-1)

Ports:
clk  in  1  clock
reset  in  1  reset
req_valid_i  in  N_REQ  per-requester request valid
req_ready_o  out  N_REQ  per-requester accept strobe, at most one bit set
req_feat_i  in  N_REQ*NFEAT*DW  feature vectors; requester k occupies bits [(k+1)*NFEAT*DW-1 : k*NFEAT*DW]
eng_start_o  out  1  one-cycle walk launch pulse
eng_feat_o  out  NFEAT*DW  captured feature vector, stable from start until done/abort
eng_done_i  in  1  engine leaf reached, eng_y_i valid this cycle
eng_y_i  in  DW  engine leaf result
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumer ready
rsp_id_o  out  IDW  requester id of response
rsp_y_o  out  DW  result (0 on timeout)
rsp_err_o  out  1  1 = walk aborted by timeout
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On reset: state IDLE; rr_ptr=0; timer=0. All outputs 0: req_ready_o, eng_start_o, eng_feat_o, rsp_*, busy_o. Reset mid-walk abandons the walk with no response. Engine sequencing after reset is the engine's own reset's concern.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid_i is set, grant the first set bit scanning upward from rr_ptr, modulo N_REQ. Grant means:
  - req_ready_o[g]=1 combinationally in this cycle; this is the handshake.
  - Capture the slice of req_feat_i into eng_feat_o and store id g.
  - Set rr_ptr=(g+1) mod N_REQ.
  - Next state is ISSUE.
  If no request is valid, stay in IDLE with all req_ready_o = 0.
- ISSUE: eng_start_o=1 for exactly this cycle; timer=0; next state WAIT. eng_done_i is ignored in ISSUE.
- WAIT:
  - If eng_done_i: register rsp_y_o=eng_y_i, rsp_err_o=0; next RESP.
  - Else if timer==TMO-1: rsp_y_o=0, rsp_err_o=1; next RESP.
  - Else timer+1.
  - If eng_done_i and the timeout condition occur in the same cycle, done wins (err=0).
- RESP: rsp_valid_o=1, with rsp_id_o/rsp_y_o/rsp_err_o held stable until the cycle rsp_valid_o&&rsp_ready_i. That cycle: next IDLE, rsp_valid_o deasserts the following cycle. No new grant is issued in the RESP cycle.
- Latency:
  - Grant at cycle T, eng_start_o at T+1.
  - Done sampled at cycle D≥T+2 gives rsp_valid_o from D+1.
  - Timeout gives rsp_valid_o at T+2+TMO.
  - Minimum request-to-request spacing is 4 cycles (grant, issue, done, resp).
- Fairness: a requester holding req_valid_i continuously is granted within N_REQ grants. A requester may drop req_valid_i before grant with no effect.
- eng_feat_o changes only at grant. A late eng_done_i arriving outside WAIT is ignored.
- Widths: timer is clog2(TMO+1) bits, no wrap. rr_ptr wraps N_REQ-1 to 0.

Test Plan:
- Reset then single request: N_REQ=4, req_valid_i=0010, feat=32'h04030201. Expect req_ready_o=0010 for 1 cycle, eng_start_o pulse next cycle, eng_feat_o=32'h04030201. Engine eng_done_i 3 cycles later with y=8'h5A. Expect rsp_valid_o, rsp_id_o=1, rsp_y_o=5A, rsp_err_o=0.
- Round robin: all four req_valid_i held high, consumer always ready, engine done 2 cycles after start. Expect grant order 0,1,2,3,0,1. Each response id matches the grant order.
- Timeout: TMO=8, engine never asserts done. Expect rsp_valid_o exactly 10 cycles after grant, with rsp_err_o=1 and rsp_y_o=0. eng_done_i pulsed afterwards is ignored.
- Done/timeout collision: TMO=8, eng_done_i at the 8th WAIT cycle with y=8'h11. Expect rsp_err_o=0, rsp_y_o=11.
- Backpressure: rsp_ready_i low for 5 cycles during RESP, while requester 3 is valid. Expect outputs stable, req_ready_o=0, no eng_start_o. Grant of requester 3 occurs the cycle after ready goes high.
- Reset mid-WAIT: reset asserted in WAIT for 1 cycle. Expect all outputs 0 next cycle, rr_ptr=0, no response for the abandoned request. The next request is granted normally.
